// File: rtl/hub75_pkg.sv
// Shared HUB75 constants and the SPI pixel writer state type.
// Used by spi_pixel_writer, spi_input_sync and the scan controller.
package hub75_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        FULL    = 2'd2
    } writer_state_e;

    localparam int SYNC_STAGES             = 3;
    localparam int DEFAULT_BITS_PER_PIXEL  = 16;
    localparam int DEFAULT_PIXEL_ADDR_BITS = 10;
    localparam int DEFAULT_FRAME_PIXELS    = 1024;

endpackage

// File: rtl/spi_input_sync.sv
// Brings spi_clk, spi_mosi and spi_ss into the clk domain through a flop chain
// and produces registered rise/fall events for spi_clk and spi_ss.
module spi_input_sync
    import hub75_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_spi_clk,
    input  logic i_spi_mosi,
    input  logic i_spi_ss,
    output logic o_mosi,
    output logic o_clk_rise,
    output logic o_clk_fall,
    output logic o_ss_rise,
    output logic o_ss_fall
);

    localparam int S2 = SYNC_STAGES - 2;
    localparam int S3 = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic                   r_clk_rise;
    logic                   r_clk_fall;
    logic                   r_ss_rise;
    logic                   r_ss_fall;

    // spi_ss idles high, so its chain resets high to avoid a phantom edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clk_sync  <= '0;
            r_mosi_sync <= '0;
            r_ss_sync   <= '1;
            r_clk_rise  <= 1'b0;
            r_clk_fall  <= 1'b0;
            r_ss_rise   <= 1'b0;
            r_ss_fall   <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_spi_clk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_spi_ss};
            r_clk_rise  <= r_clk_sync[S2] & ~r_clk_sync[S3];
            r_clk_fall  <= ~r_clk_sync[S2] & r_clk_sync[S3];
            r_ss_rise   <= r_ss_sync[S2] & ~r_ss_sync[S3];
            r_ss_fall   <= ~r_ss_sync[S2] & r_ss_sync[S3];
        end
    end

    assign o_mosi     = r_mosi_sync[S3];
    assign o_clk_rise = r_clk_rise;
    assign o_clk_fall = r_clk_fall;
    assign o_ss_rise  = r_ss_rise;
    assign o_ss_fall  = r_ss_fall;

endmodule

// File: rtl/spi_pixel_writer.sv
// Assembles SPI pixel words into writes to the back half of a double-buffered
// pixel RAM and flips the displayed half only on a complete frame.
// Optional status readback on spi_miso: define SPI_PIXEL_WRITER_STATUS_EN.
module spi_pixel_writer
    import hub75_pkg::*;
#(
    parameter int BITS_PER_PIXEL  = DEFAULT_BITS_PER_PIXEL,
    parameter int PIXEL_ADDR_BITS = DEFAULT_PIXEL_ADDR_BITS,
    parameter int FRAME_PIXELS    = DEFAULT_FRAME_PIXELS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       spi_clk,
    input  logic                       spi_mosi,
    input  logic                       spi_ss,
    output logic                       spi_miso,
    output logic                       wr_en,
    output logic [PIXEL_ADDR_BITS:0]   wr_addr,
    output logic [BITS_PER_PIXEL-1:0]  wr_data,
    output logic                       display_buffer,
    output logic                       frame_done,
    output logic                       short_frame,
    output writer_state_e              o_dbg_state
);

    localparam int BIT_CNT_W = $clog2(BITS_PER_PIXEL);
    localparam logic [BIT_CNT_W-1:0]       LAST_BIT = BIT_CNT_W'(BITS_PER_PIXEL - 1);
    localparam logic [PIXEL_ADDR_BITS-1:0] LAST_PIX = PIXEL_ADDR_BITS'(FRAME_PIXELS - 1);

    logic w_mosi;
    logic w_clk_rise;
    logic w_ss_rise;
    logic w_ss_fall;

    writer_state_e               r_state;
    logic [BIT_CNT_W-1:0]        r_bit_cnt;
    logic [PIXEL_ADDR_BITS-1:0]  r_pix_idx;
    logic [BITS_PER_PIXEL-1:0]   r_shreg;
    logic                        r_wr_en;
    logic [PIXEL_ADDR_BITS:0]    r_wr_addr;
    logic [BITS_PER_PIXEL-1:0]   r_wr_data;
    logic                        r_display_buffer;
    logic                        r_frame_done;
    logic                        r_short_frame;

    logic [BITS_PER_PIXEL-1:0]   w_shift;
    logic                        w_word_done;
    logic                        w_frame_full;
    logic                        w_commit;

`ifdef SPI_PIXEL_WRITER_STATUS_EN
    logic w_clk_fall;

    spi_input_sync u_sync (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_spi_clk  (spi_clk),
        .i_spi_mosi (spi_mosi),
        .i_spi_ss   (spi_ss),
        .o_mosi     (w_mosi),
        .o_clk_rise (w_clk_rise),
        .o_clk_fall (w_clk_fall),
        .o_ss_rise  (w_ss_rise),
        .o_ss_fall  (w_ss_fall)
    );
`else
    spi_input_sync u_sync (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_spi_clk  (spi_clk),
        .i_spi_mosi (spi_mosi),
        .i_spi_ss   (spi_ss),
        .o_mosi     (w_mosi),
        .o_clk_rise (w_clk_rise),
        .o_clk_fall (),
        .o_ss_rise  (w_ss_rise),
        .o_ss_fall  (w_ss_fall)
    );
`endif

    assign w_shift     = {r_shreg[BITS_PER_PIXEL-2:0], w_mosi};
    assign w_word_done = (r_state == RECEIVE) && w_clk_rise && (r_bit_cnt == LAST_BIT);
    // A bit landing in the same cycle as spi_ss rising still counts toward the frame.
    assign w_frame_full = (r_state == FULL) || (w_word_done && (r_pix_idx == LAST_PIX));
    assign w_commit     = (r_state != IDLE) && w_ss_rise && w_frame_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_bit_cnt        <= '0;
            r_pix_idx        <= '0;
            r_shreg          <= '0;
            r_wr_en          <= 1'b0;
            r_wr_addr        <= '0;
            r_wr_data        <= '0;
            r_display_buffer <= 1'b0;
            r_frame_done     <= 1'b0;
            r_short_frame    <= 1'b0;
        end else begin
            r_wr_en       <= 1'b0;
            r_frame_done  <= 1'b0;
            r_short_frame <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_ss_fall) begin
                        r_state   <= RECEIVE;
                        r_bit_cnt <= '0;
                        r_pix_idx <= '0;
                    end
                end
                RECEIVE, FULL: begin
                    if ((r_state == RECEIVE) && w_clk_rise) begin
                        r_shreg <= w_shift;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_wr_en   <= 1'b1;
                            r_wr_data <= w_shift;
                            r_wr_addr <= {~r_display_buffer, r_pix_idx};
                            r_bit_cnt <= '0;
                            r_pix_idx <= r_pix_idx + 1'b1;
                            if (r_pix_idx == LAST_PIX) begin
                                r_state <= FULL;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    if (w_ss_rise) begin
                        r_state   <= IDLE;
                        r_bit_cnt <= '0;
                        if (w_frame_full) begin
                            r_display_buffer <= ~r_display_buffer;
                            r_frame_done     <= 1'b1;
                        end else begin
                            r_short_frame <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SPI_PIXEL_WRITER_STATUS_EN
    logic [7:0] r_frame_count;
    logic [7:0] r_snap;
    logic       r_miso;

    // The snapshot rotates so it repeats every 8 bits for as long as the host clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_count <= '0;
            r_snap        <= '0;
            r_miso        <= 1'b0;
        end else begin
            if (w_commit) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
            if ((r_state == IDLE) && w_ss_fall) begin
                r_snap <= r_frame_count;
                r_miso <= r_frame_count[7];
            end else if ((r_state != IDLE) && w_ss_rise) begin
                r_miso <= 1'b0;
            end else if ((r_state != IDLE) && w_clk_fall) begin
                r_snap <= {r_snap[6:0], r_snap[7]};
                r_miso <= r_snap[6];
            end
        end
    end

    assign spi_miso = r_miso;
`else
    assign spi_miso = 1'b0;
`endif

    assign wr_en          = r_wr_en;
    assign wr_addr        = r_wr_addr;
    assign wr_data        = r_wr_data;
    assign display_buffer = r_display_buffer;
    assign frame_done     = r_frame_done;
    assign short_frame    = r_short_frame;
    assign o_dbg_state    = r_state;

endmodule

// File: doc/spi_pixel_writer.md
Name: spi_pixel_writer

Overview:
- Receives pixel data from the host SPI link and writes it into the double-buffered pixel RAM that the HUB75 scan controller reads.
- Samples spi_clk, spi_mosi and spi_ss in the system clock domain and assembles them into pixel words.
- Emits a single-cycle RAM write strobe with address and data for each completed pixel word.
- Flips the displayed buffer only after a complete frame has been received, so the panel never shows a torn frame.

Parameters:
- BITS_PER_PIXEL, 16, pixel word width; RGB fields are packed MSB-first as the scan controller expects.
- PIXEL_ADDR_BITS, 10, per-buffer pixel address width; wr_addr is PIXEL_ADDR_BITS+1 wide.
- FRAME_PIXELS, 1024, number of pixels in a complete frame; must be ≤ 2**PIXEL_ADDR_BITS.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- spi_clk  input  1  host SPI clock, asynchronous to clk (mode 0).
- spi_mosi  input  1  host serial data, MSB first.
- spi_ss  input  1  host slave select, active low; low = frame in progress.
- spi_miso  output  1  serial status back to the host.
- wr_en  output  1  one-cycle RAM write strobe.
- wr_addr  output  PIXEL_ADDR_BITS+1  RAM address = {back buffer bit, pixel index}.
- wr_data  output  BITS_PER_PIXEL  assembled pixel word.
- display_buffer  output  1  buffer half currently shown; the scan controller uses it as its read-address MSB.
- frame_done  output  1  one-cycle pulse when a complete frame is committed.
- short_frame  output  1  one-cycle pulse when spi_ss rises before FRAME_PIXELS pixels have arrived.

Behaviour:
- Reset values: every output is 0, the state is IDLE, and all counters are cleared. Reset mid-frame drops the partial frame; display_buffer returns to 0.
- Input sampling: each SPI input passes through a 3-flop chain. A rise or fall event is detected from the 2nd and 3rd flops. spi_clk must be ≤ clk/6.
- States:
  - IDLE: waits for a synchronized spi_ss fall, then goes to RECEIVE with bit_cnt=0 and pix_idx=0.
  - RECEIVE: on each spi_clk rise, shift mosi into shreg (MSB first) and increment bit_cnt.
    - When bit_cnt reaches BITS_PER_PIXEL-1 and a rise occurs, the next cycle drives wr_en=1, wr_data=shreg, wr_addr={~display_buffer, pix_idx}.
    - bit_cnt then returns to 0 and pix_idx increments.
    - After writing pixel FRAME_PIXELS-1, go to FULL.
  - FULL: further spi_clk rises are ignored; no writes, no address wrap.
- Frame end (synchronized spi_ss rise, in RECEIVE or FULL):
  - From FULL: toggle display_buffer and pulse frame_done in the same cycle.
  - From RECEIVE: pulse short_frame and leave display_buffer unchanged.
  - In both cases, return to IDLE and discard any partial bits.
- Simultaneous events: if a spi_clk rise and a spi_ss rise are detected in the same cycle, the bit is accepted first. The frame-end decision then uses the updated count, so the final pixel's wr_en and frame_done occur in the same cycle.
- Other spi_ss behaviour:
  - An spi_ss rise seen in IDLE is ignored.
  - spi_clk activity while spi_ss is high is ignored.
- Latency: wr_en is asserted 4 clk after the raw spi_clk rise of the last bit of a word (3 for synchronization and edge detect, 1 for register).
- wr_data and wr_addr hold their values between strobes.

Optional Feature:
- Macro SPI_PIXEL_WRITER_STATUS_EN, when defined:
  - Adds an 8-bit frame_count that increments, wrapping, on each frame_done.
  - frame_count is snapshotted at the spi_ss fall.
  - spi_miso shifts out the snapshot MSB-first, updating on each synchronized spi_clk fall and repeating every 8 bits.
  - spi_miso is 0 while spi_ss is high.
- Macro not defined: spi_miso is tied to 0 and there is no frame counter.

Decomposition:
- Shared package hub75_pkg holds:
  - the writer state enum (IDLE, RECEIVE, FULL);
  - constant SYNC_STAGES=3;
  - the default BITS_PER_PIXEL and FRAME_PIXELS constants shared with the scan controller.
- One sub-module, spi_input_sync: the 3-flop synchronizer for spi_clk, spi_mosi and spi_ss, with registered rise and fall event outputs for spi_clk and spi_ss.

Test Plan:
- Reset, then send a full frame of 1024 pixels with word = index. Expect 1024 wr_en pulses, wr_addr 0x400..0x7FF, wr_data 0x0000..0x03FF. After spi_ss rises, expect one frame_done pulse and display_buffer=1.
- Second full frame: writes go to 0x000..0x3FF and display_buffer returns to 0.
- Drop spi_ss high after 10 pixels plus 5 bits. Expect 10 writes, a short_frame pulse, display_buffer unchanged, and the next frame starting at pix_idx 0.
- Send 1030 pixels: exactly 1024 writes, no write to address 0x000 of the front buffer, and frame_done on the spi_ss rise.
- spi_ss rises in the same clk as the final spi_clk edge: the last wr_en and frame_done occur in the same cycle.
- Assert reset mid-pixel 500: all outputs are 0 the next cycle and no flip occurs. With SPI_PIXEL_WRITER_STATUS_EN defined, after 3 frames spi_miso reads 0x03 MSB-first.
